pingpong_stream_buffer: RTL and testbench
=========================================

Name: pingpong_stream_buffer

Overview:
- Parametrised double (ping-pong) buffer for streaming map/note data into the VGA/audio datapath.
- A producer fills one bank through a valid/ready write port while a consumer drains the other bank through an enable-based read port.
- Banks swap automatically when one frame is complete and the other is free.
- Single clock domain: rate control is done with producer/consumer enables, not a divided clock. Optional repeat mode replays the last frame when no new frame is ready.

Parameters:
DATA_W, 8, word width
ADDR_W, 5, bank address width; bank depth DEPTH = 2**ADDR_W words
FCNT_W, 16, width of frame swap counter

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  reset; synchronous, active-low
wr_valid  in  1  producer has a word
wr_data  in  DATA_W  producer word
wr_ready  out  1  write bank can accept; combinational = !w_full
rd_en  in  1  consumer requests next word
repeat_en  in  1  1 = replay current read frame when no new frame is ready
rd_data  out  DATA_W  read word, registered
rd_valid  out  1  rd_data valid this cycle
rd_last  out  1  qualifies the last word of a frame (with rd_valid)
swap  out  1  one-cycle pulse on each bank swap
underrun  out  1  one-cycle pulse: rd_en seen with no readable frame
frame_cnt  out  FCNT_W  number of swaps, wraps modulo 2**FCNT_W

Behaviour:
- State: wr_bank (read bank = !wr_bank), w_addr, r_addr, w_full, r_full.
- Reset (resetn=0 at an edge):
  - wr_bank=0, w_addr=0, r_addr=0, w_full=0, r_full=0.
  - rd_data=0, rd_valid=0, rd_last=0, swap=0, underrun=0, frame_cnt=0.
  - wr_ready=1 after reset.
  - Reset mid-frame discards both banks' status; memory contents are not cleared.
- Write accept:
  - wacc = wr_valid && !w_full.
  - Writes wr_data to bank[wr_bank][w_addr] and increments w_addr.
  - wdone = wacc && w_addr==DEPTH-1.
- Read accept:
  - racc = rd_en && r_full.
  - Reads bank[!wr_bank][r_addr] and increments r_addr.
  - rdone = racc && r_addr==DEPTH-1.
- Latency:
  - rd_valid <= racc; rd_last <= rdone.
  - rd_data updated with the addressed word at the racc edge, so it is valid exactly 1 cycle after rd_en.
  - rd_data holds its value when rd_valid=0.
- underrun <= rd_en && !r_full.
- Swap rule, evaluated at every edge:
  - frame_rdy = w_full || wdone; r_free = !r_full || rdone.
  - If frame_rdy && r_free: wr_bank toggles, w_full=0, w_addr=0, r_full=1, r_addr=0, swap pulses, frame_cnt++.
  - Swap has priority over repeat. A full frame waiting when reading ends is swapped in on the same edge, with no bubble.
  - Simultaneous wdone and rdone: swap, and the just-written bank becomes the read bank.
  - wdone with the read bank empty: swap on that same edge; the new frame is readable the next cycle.
- No swap:
  - w_full <= w_full || wdone.
  - On rdone with repeat_en=1: r_full stays 1, r_addr=0, and the same frame replays.
  - On rdone with repeat_en=0: r_full=0, and the read bank is released.
- Backpressure:
  - While w_full=1, wr_ready=0 and producer data is not accepted; no word is ever dropped or overwritten.
- Address wrap:
  - w_addr and r_addr wrap DEPTH-1 -> 0 only through the done/swap paths above.
- Memory: two DEPTH x DATA_W arrays with synchronous read, inferable as block RAM.
- Read and write never target the same bank, so no read-during-write hazard exists.

Test Plan (DATA_W=8, ADDR_W=2, DEPTH=4):
- Reset then idle: all outputs 0, wr_ready=1; pulse rd_en -> underrun=1 next cycle, rd_valid stays 0.
- Write 0x10..0x13 continuously: swap pulse at the edge of the 4th write, frame_cnt=1, wr_ready stays 1. rd_en held 4 cycles -> rd_data 0x10,0x11,0x12,0x13 one cycle later each; rd_last with 0x13.
- Backpressure: write 0x20..0x23 (swap), write 0x30..0x33 with no reads -> wr_ready=0 after 0x33. A 5th word 0x34 is held, not accepted. Read 4 words -> 0x20..0x23; swap on the last read edge; wr_ready=1 next cycle; 0x34 accepted into the freed bank; next reads return 0x30..0x33.
- Repeat mode: repeat_en=1, one frame 0x40..0x43 loaded, no further writes; read 8 words -> 0x40..0x43 twice, rd_last twice, frame_cnt unchanged. With repeat_en=0, the 9th rd_en -> underrun.
- Simultaneous: final write and final read on the same edge -> single swap pulse, frame_cnt +1. The next 4 reads return the just-written frame.
- Reset mid-frame: after 2 writes and 1 read, assert resetn=0 one cycle -> all flags and outputs back to reset values. A next full 4-word write swaps with frame_cnt=1.

Source files
------------

// File: rtl/pingpong_stream_buffer_if.sv
// Stream interface of the ping-pong buffer: producer write port, consumer read port and status.
// The master side drives the producer and consumer inputs; the slave side is the buffer.
interface pingpong_stream_buffer_if #(
    parameter int DATA_W = 8,
    parameter int FCNT_W = 16
);
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_en;
    logic              repeat_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              swap;
    logic              underrun;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output wr_valid, wr_data, rd_en, repeat_en,
        input  wr_ready, rd_data, rd_valid, rd_last, swap, underrun, frame_cnt
    );

    modport slave (
        input  wr_valid, wr_data, rd_en, repeat_en,
        output wr_ready, rd_data, rd_valid, rd_last, swap, underrun, frame_cnt
    );
endinterface

// File: rtl/pingpong_stream_buffer.sv
// Double-buffered frame store: the producer fills one bank while the consumer drains the other,
// and the banks swap as soon as a complete frame meets a free read bank.
module pingpong_stream_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int FCNT_W = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    pingpong_stream_buffer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1'b1);

    logic [DATA_W-1:0] mem0_r [DEPTH];
    logic [DATA_W-1:0] mem1_r [DEPTH];

    logic              wr_bank_r;
    logic [ADDR_W-1:0] w_addr_r;
    logic [ADDR_W-1:0] r_addr_r;
    logic              w_full_r;
    logic              r_full_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              rd_last_r;
    logic              swap_r;
    logic              underrun_r;
    logic [FCNT_W-1:0] frame_cnt_r;

    logic              wacc_s;
    logic              wdone_s;
    logic              racc_s;
    logic              rdone_s;
    logic              do_swap_s;
    logic [DATA_W-1:0] rd_word_s;

    // Accept/done qualifiers and the swap decision for the coming edge.
    always_comb begin
        wacc_s    = bus.wr_valid && !w_full_r;
        wdone_s   = wacc_s && (w_addr_r == ADDR_LAST);
        racc_s    = bus.rd_en && r_full_r;
        rdone_s   = racc_s && (r_addr_r == ADDR_LAST);
        do_swap_s = (w_full_r || wdone_s) && (!r_full_r || rdone_s);
        if (wr_bank_r) begin
            rd_word_s = mem0_r[r_addr_r];
        end else begin
            rd_word_s = mem1_r[r_addr_r];
        end
    end

    // Bank 0 write port.
    always_ff @(posedge clk) begin
        if (wacc_s && !wr_bank_r) begin
            mem0_r[w_addr_r] <= bus.wr_data;
        end
    end

    // Bank 1 write port.
    always_ff @(posedge clk) begin
        if (wacc_s && wr_bank_r) begin
            mem1_r[w_addr_r] <= bus.wr_data;
        end
    end

    // Bank ownership, addressing, frame status and registered read-side outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_bank_r   <= 1'b0;
            w_addr_r    <= '0;
            r_addr_r    <= '0;
            w_full_r    <= 1'b0;
            r_full_r    <= 1'b0;
            rd_data_r   <= '0;
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
            swap_r      <= 1'b0;
            underrun_r  <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            rd_valid_r <= racc_s;
            rd_last_r  <= rdone_s;
            underrun_r <= bus.rd_en && !r_full_r;
            swap_r     <= do_swap_s;
            if (racc_s) begin
                rd_data_r <= rd_word_s;
                r_addr_r  <= r_addr_r + ADDR_ONE;
            end
            if (wacc_s) begin
                w_addr_r <= w_addr_r + ADDR_ONE;
            end
            if (do_swap_s) begin
                // A swap outranks repeat: fresh data always wins over a replay.
                wr_bank_r   <= ~wr_bank_r;
                w_full_r    <= 1'b0;
                w_addr_r    <= '0;
                r_full_r    <= 1'b1;
                r_addr_r    <= '0;
                frame_cnt_r <= frame_cnt_r + FCNT_ONE;
            end else begin
                w_full_r <= w_full_r || wdone_s;
                if (rdone_s) begin
                    if (bus.repeat_en) begin
                        r_addr_r <= '0;
                    end else begin
                        r_full_r <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.wr_ready  = !w_full_r;
    assign bus.rd_data   = rd_data_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_last   = rd_last_r;
    assign bus.swap      = swap_r;
    assign bus.underrun  = underrun_r;
    assign bus.frame_cnt = frame_cnt_r;
endmodule

// File: tb/tb_pingpong_stream_buffer.sv
// Directed bench for pingpong_stream_buffer with DEPTH=4: a per-cycle vector table plus
// hand-written sequences for simultaneous swap and mid-frame reset.
module tb_pingpong_stream_buffer;
    typedef struct packed {
        logic       resetn;
        logic       wr_valid;
        logic [7:0] wr_data;
        logic       rd_en;
        logic       repeat_en;
    } ins_t;

    typedef struct packed {
        logic        wr_ready;
        logic        rd_valid;
        logic [7:0]  rd_data;
        logic        rd_last;
        logic        swap;
        logic        underrun;
        logic [15:0] frame_cnt;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t o;
    } vec_t;

    logic clk;
    logic resetn;
    int   pass_cnt;
    int   total_cnt;
    vec_t vecs[$];

    pingpong_stream_buffer_if #(.DATA_W(8), .FCNT_W(16)) bus ();

    pingpong_stream_buffer #(.DATA_W(8), .ADDR_W(2), .FCNT_W(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic wv, input logic [7:0] wd,
                                input logic re, input logic rep,
                                input logic rdy, input logic rv, input logic [7:0] rdd,
                                input logic rl, input logic sw, input logic un,
                                input logic [15:0] fc);
        vec_t v;
        v.i = '{resetn: rst, wr_valid: wv, wr_data: wd, rd_en: re, repeat_en: rep};
        v.o = '{wr_ready: rdy, rd_valid: rv, rd_data: rdd, rd_last: rl, swap: sw,
                underrun: un, frame_cnt: fc};
        return v;
    endfunction

    // Drive one cycle of inputs, then compare all outputs just after the rising edge.
    task automatic run_vec(input string tag, input vec_t v);
        outs_t act;
        @(negedge clk);
        resetn        = v.i.resetn;
        bus.wr_valid  = v.i.wr_valid;
        bus.wr_data   = v.i.wr_data;
        bus.rd_en     = v.i.rd_en;
        bus.repeat_en = v.i.repeat_en;
        @(posedge clk);
        #1;
        act = '{wr_ready: bus.wr_ready, rd_valid: bus.rd_valid, rd_data: bus.rd_data,
                rd_last: bus.rd_last, swap: bus.swap, underrun: bus.underrun,
                frame_cnt: bus.frame_cnt};
        total_cnt++;
        if (act === v.o) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got rdy=%b rv=%b rd=%h last=%b swap=%b und=%b fc=%0d, want rdy=%b rv=%b rd=%h last=%b swap=%b und=%b fc=%0d",
                     tag, act.wr_ready, act.rd_valid, act.rd_data, act.rd_last, act.swap,
                     act.underrun, act.frame_cnt, v.o.wr_ready, v.o.rd_valid, v.o.rd_data,
                     v.o.rd_last, v.o.swap, v.o.underrun, v.o.frame_cnt);
        end
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        resetn        = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;
        bus.rd_en     = 1'b0;
        bus.repeat_en = 1'b0;

        //            rst  wv    wd     re    rep   rdy   rv    rd     rl    sw    un    fc
        // reset, idle, underrun on empty read
        vecs.push_back(mk(1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,16'd0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,16'd0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,8'h00,1'b0,1'b0,1'b1,16'd0));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,16'd0));
        // first frame 0x10..0x13, swap on 4th write, then drain
        vecs.push_back(mk(1'b1,1'b1,8'h10,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,16'd0));
        vecs.push_back(mk(1'b1,1'b1,8'h11,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,16'd0));
        vecs.push_back(mk(1'b1,1'b1,8'h12,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,16'd0));
        vecs.push_back(mk(1'b1,1'b1,8'h13,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,16'd1));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h10,1'b0,1'b0,1'b0,16'd1));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h11,1'b0,1'b0,1'b0,16'd1));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h12,1'b0,1'b0,1'b0,16'd1));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h13,1'b1,1'b0,1'b0,16'd1));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h13,1'b0,1'b0,1'b0,16'd1));
        // backpressure: 0x20..0x23 swaps, 0x30..0x33 fills, 0x34 is held off
        vecs.push_back(mk(1'b1,1'b1,8'h20,1'b0,1'b0, 1'b1,1'b0,8'h13,1'b0,1'b0,1'b0,16'd1));
        vecs.push_back(mk(1'b1,1'b1,8'h21,1'b0,1'b0, 1'b1,1'b0,8'h13,1'b0,1'b0,1'b0,16'd1));
        vecs.push_back(mk(1'b1,1'b1,8'h22,1'b0,1'b0, 1'b1,1'b0,8'h13,1'b0,1'b0,1'b0,16'd1));
        vecs.push_back(mk(1'b1,1'b1,8'h23,1'b0,1'b0, 1'b1,1'b0,8'h13,1'b0,1'b1,1'b0,16'd2));
        vecs.push_back(mk(1'b1,1'b1,8'h30,1'b0,1'b0, 1'b1,1'b0,8'h13,1'b0,1'b0,1'b0,16'd2));
        vecs.push_back(mk(1'b1,1'b1,8'h31,1'b0,1'b0, 1'b1,1'b0,8'h13,1'b0,1'b0,1'b0,16'd2));
        vecs.push_back(mk(1'b1,1'b1,8'h32,1'b0,1'b0, 1'b1,1'b0,8'h13,1'b0,1'b0,1'b0,16'd2));
        vecs.push_back(mk(1'b1,1'b1,8'h33,1'b0,1'b0, 1'b0,1'b0,8'h13,1'b0,1'b0,1'b0,16'd2));
        vecs.push_back(mk(1'b1,1'b1,8'h34,1'b0,1'b0, 1'b0,1'b0,8'h13,1'b0,1'b0,1'b0,16'd2));
        vecs.push_back(mk(1'b1,1'b1,8'h34,1'b1,1'b0, 1'b0,1'b1,8'h20,1'b0,1'b0,1'b0,16'd2));
        vecs.push_back(mk(1'b1,1'b1,8'h34,1'b1,1'b0, 1'b0,1'b1,8'h21,1'b0,1'b0,1'b0,16'd2));
        vecs.push_back(mk(1'b1,1'b1,8'h34,1'b1,1'b0, 1'b0,1'b1,8'h22,1'b0,1'b0,1'b0,16'd2));
        vecs.push_back(mk(1'b1,1'b1,8'h34,1'b1,1'b0, 1'b1,1'b1,8'h23,1'b1,1'b1,1'b0,16'd3));
        vecs.push_back(mk(1'b1,1'b1,8'h34,1'b0,1'b0, 1'b1,1'b0,8'h23,1'b0,1'b0,1'b0,16'd3));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h30,1'b0,1'b0,1'b0,16'd3));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h31,1'b0,1'b0,1'b0,16'd3));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h32,1'b0,1'b0,1'b0,16'd3));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h33,1'b1,1'b0,1'b0,16'd3));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h33,1'b0,1'b0,1'b0,16'd3));
        // complete the frame that started with 0x34, then drain it
        vecs.push_back(mk(1'b1,1'b1,8'h35,1'b0,1'b0, 1'b1,1'b0,8'h33,1'b0,1'b0,1'b0,16'd3));
        vecs.push_back(mk(1'b1,1'b1,8'h36,1'b0,1'b0, 1'b1,1'b0,8'h33,1'b0,1'b0,1'b0,16'd3));
        vecs.push_back(mk(1'b1,1'b1,8'h37,1'b0,1'b0, 1'b1,1'b0,8'h33,1'b0,1'b1,1'b0,16'd4));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h34,1'b0,1'b0,1'b0,16'd4));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h35,1'b0,1'b0,1'b0,16'd4));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h36,1'b0,1'b0,1'b0,16'd4));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h37,1'b1,1'b0,1'b0,16'd4));
        // repeat mode: 0x40..0x43 replayed twice, released on the 8th read, 9th underruns
        vecs.push_back(mk(1'b1,1'b1,8'h40,1'b0,1'b0, 1'b1,1'b0,8'h37,1'b0,1'b0,1'b0,16'd4));
        vecs.push_back(mk(1'b1,1'b1,8'h41,1'b0,1'b0, 1'b1,1'b0,8'h37,1'b0,1'b0,1'b0,16'd4));
        vecs.push_back(mk(1'b1,1'b1,8'h42,1'b0,1'b0, 1'b1,1'b0,8'h37,1'b0,1'b0,1'b0,16'd4));
        vecs.push_back(mk(1'b1,1'b1,8'h43,1'b0,1'b0, 1'b1,1'b0,8'h37,1'b0,1'b1,1'b0,16'd5));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,1'b1,8'h40,1'b0,1'b0,1'b0,16'd5));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,1'b1,8'h41,1'b0,1'b0,1'b0,16'd5));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,1'b1,8'h42,1'b0,1'b0,1'b0,16'd5));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,1'b1,8'h43,1'b1,1'b0,1'b0,16'd5));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,1'b1,8'h40,1'b0,1'b0,1'b0,16'd5));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,1'b1,8'h41,1'b0,1'b0,1'b0,16'd5));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b1, 1'b1,1'b1,8'h42,1'b0,1'b0,1'b0,16'd5));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h43,1'b1,1'b0,1'b0,16'd5));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b0,8'h43,1'b0,1'b0,1'b1,16'd5));
        vecs.push_back(mk(1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h43,1'b0,1'b0,1'b0,16'd5));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Simultaneous final write and final read: one swap, new frame readable with no bubble.
        for (int k = 0; k < 4; k++) begin
            run_vec("sim_fill", mk(1'b1,1'b1,8'h50 + 8'(k),1'b0,1'b0, 1'b1,1'b0,8'h43,1'b0,
                                   (k == 3) ? 1'b1 : 1'b0,1'b0,(k == 3) ? 16'd6 : 16'd5));
        end
        for (int k = 0; k < 4; k++) begin
            run_vec("sim_overlap", mk(1'b1,1'b1,8'h60 + 8'(k),1'b1,1'b0, 1'b1,1'b1,8'h50 + 8'(k),
                                      (k == 3) ? 1'b1 : 1'b0,(k == 3) ? 1'b1 : 1'b0,1'b0,
                                      (k == 3) ? 16'd7 : 16'd6));
        end
        for (int k = 0; k < 4; k++) begin
            run_vec("sim_drain", mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h60 + 8'(k),
                                    (k == 3) ? 1'b1 : 1'b0,1'b0,1'b0,16'd7));
        end

        // Reset in the middle of a frame, then a fresh frame counts from one again.
        for (int k = 0; k < 4; k++) begin
            run_vec("rst_prefill", mk(1'b1,1'b1,8'h70 + 8'(k),1'b0,1'b0, 1'b1,1'b0,8'h63,1'b0,
                                      (k == 3) ? 1'b1 : 1'b0,1'b0,(k == 3) ? 16'd8 : 16'd7));
        end
        run_vec("rst_wr0", mk(1'b1,1'b1,8'h80,1'b0,1'b0, 1'b1,1'b0,8'h63,1'b0,1'b0,1'b0,16'd8));
        run_vec("rst_wr1", mk(1'b1,1'b1,8'h81,1'b0,1'b0, 1'b1,1'b0,8'h63,1'b0,1'b0,1'b0,16'd8));
        run_vec("rst_rd0", mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h70,1'b0,1'b0,1'b0,16'd8));
        run_vec("rst_pulse", mk(1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,16'd0));
        for (int k = 0; k < 4; k++) begin
            run_vec("rst_refill", mk(1'b1,1'b1,8'h90 + 8'(k),1'b0,1'b0, 1'b1,1'b0,8'h00,1'b0,
                                     (k == 3) ? 1'b1 : 1'b0,1'b0,(k == 3) ? 16'd1 : 16'd0));
        end
        for (int k = 0; k < 4; k++) begin
            run_vec("rst_drain", mk(1'b1,1'b0,8'h00,1'b1,1'b0, 1'b1,1'b1,8'h90 + 8'(k),
                                    (k == 3) ? 1'b1 : 1'b0,1'b0,1'b0,16'd1));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
